// File: rtl/lcd_fb_pkg.sv
// lcd_fb_pkg
// Shared definitions for the LCD frame buffer bank controller.
//   fb_state_t   : write-side sequencer states
//   LCD_W/LCD_H  : visible LCD geometry
//   FRAME_PIX    : pixels in one complete frame
//   AHEAD_THRESH : write-pointer lead (60 lines) after which scan-out may
//                  safely chase the bank that is still being written
package lcd_fb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DONE   = 2'd2,
    FROZEN = 2'd3
  } fb_state_t;

  localparam int LCD_W        = 160;
  localparam int LCD_H        = 144;
  localparam int FRAME_PIX    = LCD_W * LCD_H;
  localparam int AHEAD_THRESH = LCD_W * 60;

endpackage

// File: rtl/lcd_fb_bank_ctrl.sv
// lcd_fb_bank_ctrl
// Double-buffer bank scheduler for the LCD frame buffer (clk_sys domain).
// Sequences the write side (pixel qualification, write address, frame
// completion, freeze and restart tracking) and picks the bank scan-out
// reads at every output frame start.
//
// Ports:
//   clk_sys        : system clock
//   reset_n        : asynchronous active-low reset
//   wr_frame_start : pulse, pixel source begins a new frame
//   wr_pix         : pulse, one pixel strobe
//   freeze         : level, suppresses all writes while high
//   double_buffer  : level, 1 = ping-pong two banks, 0 = bank 0 only
//   rd_frame_start : pulse, scan-out is about to start a frame
//   wr_en          : RAM write enable
//   wr_addr        : RAM write address {bank, pixel pointer}
//   rd_bank        : bank selected for scan-out
//   frame_done     : pulse, the last pixel of a frame was accepted
//   overflow       : sticky, a pixel arrived after the frame was complete
//   restart_cnt    : saturating count of frames abandoned before completion
module lcd_fb_bank_ctrl
  import lcd_fb_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int FRAME_PIX    = lcd_fb_pkg::FRAME_PIX,
  parameter int AHEAD_THRESH = lcd_fb_pkg::AHEAD_THRESH
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              wr_frame_start,
  input  logic              wr_pix,
  input  logic              freeze,
  input  logic              double_buffer,
  input  logic              rd_frame_start,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        restart_cnt
);

  // A frame must fit in one bank and the chase threshold must lie inside it.
  if ((FRAME_PIX > (1 << ADDR_W)) || (AHEAD_THRESH >= FRAME_PIX)) begin : g_bad_params
    $error("lcd_fb_bank_ctrl: FRAME_PIX must fit in 2^ADDR_W and AHEAD_THRESH must be below FRAME_PIX");
  end

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] THRESH_PTR = ADDR_W'(AHEAD_THRESH);

  fb_state_t         state_q;
  logic              in_bank_q;
  logic              last_bank_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              rd_bank_q;
  logic              rd_bank_d;
  logic              frame_done_q;
  logic              overflow_q;
  logic [7:0]        restart_cnt_q;
  logic [7:0]        restart_cnt_d;

  // Scan-out bank choice. Uses the pre-edge write state so a coincident
  // frame start or completion never influences this frame's decision.
  // Reading the bank under construction is only allowed once the writer is
  // far enough ahead that scan-out cannot overtake it.
  always_comb begin
    rd_bank_d = rd_bank_q;
    if (rd_frame_start) begin
      if (!double_buffer) begin
        rd_bank_d = 1'b0;
      end else if ((state_q == WRITE) && (wr_ptr_q >= THRESH_PTR)) begin
        rd_bank_d = in_bank_q;
      end else begin
        rd_bank_d = last_bank_q;
      end
    end
  end

  // Restart counter saturates instead of wrapping.
  always_comb begin
    restart_cnt_d = restart_cnt_q;
    if (restart_cnt_q != 8'hFF) begin
      restart_cnt_d = restart_cnt_q + 8'd1;
    end
  end

  // Write-side sequencer. Freeze overrides everything and holds pointer and
  // bank; leaving freeze always waits in IDLE for a fresh frame start so a
  // partially written frame is never resumed mid-way.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      in_bank_q     <= 1'b0;
      last_bank_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_bank_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      restart_cnt_q <= 8'd0;
    end else begin
      rd_bank_q    <= rd_bank_d;
      frame_done_q <= 1'b0;
      if (freeze) begin
        state_q <= FROZEN;
      end else begin
        case (state_q)
          FROZEN: begin
            state_q <= IDLE;
          end
          IDLE: begin
            if (wr_frame_start) begin
              state_q  <= WRITE;
              wr_ptr_q <= '0;
            end
          end
          WRITE: begin
            if (wr_frame_start) begin
              // Early restart: same bank, start over, drop coincident pixel.
              wr_ptr_q      <= '0;
              restart_cnt_q <= restart_cnt_d;
            end else if (wr_pix) begin
              if (wr_ptr_q == LAST_PTR) begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
                last_bank_q  <= in_bank_q;
              end else begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
              end
            end
          end
          DONE: begin
            if (wr_frame_start) begin
              // Single-buffer mode pins the writer to bank 0.
              in_bank_q <= double_buffer & ~in_bank_q;
              wr_ptr_q  <= '0;
              state_q   <= WRITE;
            end else if (wr_pix) begin
              overflow_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign wr_en       = (state_q == WRITE) & wr_pix & ~wr_frame_start & ~freeze;
  assign wr_addr     = {in_bank_q, wr_ptr_q};
  assign rd_bank     = rd_bank_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign restart_cnt = restart_cnt_q;

endmodule

// File: tb/tb_lcd_fb_bank_ctrl.sv
// tb_lcd_fb_bank_ctrl
// Self-checking bench for lcd_fb_bank_ctrl: a frame-level model of the
// writer/scan-out bank rules is compared against the DUT on every falling
// clock edge, and directed scenarios pin key values by hand.
module tb_lcd_fb_bank_ctrl;

  localparam int ADDR_W = 15;
  localparam int FRAME  = 23040;
  localparam int AHEAD  = 9600;
  localparam int BANK_W = 32768;

  logic        clk_sys        = 1'b0;
  logic        reset_n        = 1'b0;
  logic        wr_frame_start = 1'b0;
  logic        wr_pix         = 1'b0;
  logic        freeze         = 1'b0;
  logic        double_buffer  = 1'b0;
  logic        rd_frame_start = 1'b0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        rd_bank;
  logic        frame_done;
  logic        overflow;
  logic [7:0]  restart_cnt;

  int errors        = 0;
  int checks        = 0;
  int frameDoneSeen = 0;

  lcd_fb_bank_ctrl #(
    .ADDR_W      (ADDR_W),
    .FRAME_PIX   (FRAME),
    .AHEAD_THRESH(AHEAD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .wr_frame_start(wr_frame_start),
    .wr_pix        (wr_pix),
    .freeze        (freeze),
    .double_buffer (double_buffer),
    .rd_frame_start(rd_frame_start),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rd_bank       (rd_bank),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .restart_cnt   (restart_cnt)
  );

  // Free-running system clock.
  always #5 clk_sys = ~clk_sys;

  // Frame-level model: is a frame being filled, is it full, is the writer
  // halted, how many pixels are in, which bank, which bank was last shown.
  bit mWriting  = 1'b0;
  bit mFull     = 1'b0;
  bit mHalted   = 1'b0;
  bit mBank     = 1'b0;
  bit mShown    = 1'b0;
  bit mRd       = 1'b0;
  bit mDone     = 1'b0;
  bit mOver     = 1'b0;
  int mCount    = 0;
  int mRestarts = 0;

  // Model update on each clock, all decisions taken from pre-edge values.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mWriting  <= 1'b0;
      mFull     <= 1'b0;
      mHalted   <= 1'b0;
      mBank     <= 1'b0;
      mShown    <= 1'b0;
      mRd       <= 1'b0;
      mDone     <= 1'b0;
      mOver     <= 1'b0;
      mCount    <= 0;
      mRestarts <= 0;
    end else begin
      if (rd_frame_start) begin
        if (!double_buffer) mRd <= 1'b0;
        else if (mWriting && mCount >= AHEAD) mRd <= mBank;
        else mRd <= mShown;
      end
      mDone <= 1'b0;
      if (freeze) begin
        mHalted  <= 1'b1;
        mWriting <= 1'b0;
        mFull    <= 1'b0;
      end else if (mHalted) begin
        mHalted <= 1'b0;
      end else if (mWriting) begin
        if (wr_frame_start) begin
          mCount <= 0;
          if (mRestarts < 255) mRestarts <= mRestarts + 1;
        end else if (wr_pix) begin
          if (mCount + 1 == FRAME) begin
            mWriting <= 1'b0;
            mFull    <= 1'b1;
            mDone    <= 1'b1;
            mShown   <= mBank;
          end else begin
            mCount <= mCount + 1;
          end
        end
      end else if (mFull) begin
        if (wr_frame_start) begin
          mFull    <= 1'b0;
          mWriting <= 1'b1;
          mCount   <= 0;
          mBank    <= double_buffer ? !mBank : 1'b0;
        end else if (wr_pix) begin
          mOver <= 1'b1;
        end
      end else if (wr_frame_start) begin
        mWriting <= 1'b1;
        mCount   <= 0;
      end
    end
  end

  // One comparison, counted, with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      checkOutput("wr_en",       32'(wr_en),       32'(mWriting && wr_pix && !wr_frame_start && !freeze));
      checkOutput("wr_addr",     32'(wr_addr),     32'(int'(mBank) * BANK_W + mCount));
      checkOutput("rd_bank",     32'(rd_bank),     32'(mRd));
      checkOutput("frame_done",  32'(frame_done),  32'(mDone));
      checkOutput("overflow",    32'(overflow),    32'(mOver));
      checkOutput("restart_cnt", 32'(restart_cnt), 32'(mRestarts));
      if (frame_done) frameDoneSeen++;
    end
  end

  // Drive one cycle of pulse inputs shortly after the rising edge.
  task automatic applyStimulus(input bit fs, input bit pix, input bit rfs);
    @(posedge clk_sys);
    #1;
    wr_frame_start = fs;
    wr_pix         = pix;
    rd_frame_start = rfs;
  endtask

  task automatic writePixels(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state, held low.
    repeat (2) @(posedge clk_sys);
    #2;
    wr_pix = 1'b1;
    #1;
    checkOutput("reset_wr_en", 32'(wr_en), 0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 0);
    checkOutput("reset_rd_bank", 32'(rd_bank), 0);
    checkOutput("reset_overflow", 32'(overflow), 0);
    checkOutput("reset_restart_cnt", 32'(restart_cnt), 0);
    wr_pix = 1'b0;
    @(posedge clk_sys);
    #1;
    reset_n       = 1'b1;
    double_buffer = 1'b1;

    // Stray pixels in IDLE are ignored.
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1 checkOutput("idle_pix_wr_en", 32'(wr_en), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // First full frame into bank 0.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (i == 0) begin
        #1 checkOutput("frame1_first_addr", 32'(wr_addr), 'h0000);
      end
      if (i == FRAME - 1) begin
        #1 checkOutput("frame1_last_addr", 32'(wr_addr), 'h59FF);
        checkOutput("frame1_last_wr_en", 32'(wr_en), 1);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("frame1_done", 32'(frame_done), 1);
    checkOutput("frame1_addr_held", 32'(wr_addr), 'h59FF);

    // Extra pixels after completion raise sticky overflow.
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1 checkOutput("done_pix_wr_en", 32'(wr_en), 0);
    writePixels(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("overflow_sticky", 32'(overflow), 1);
    checkOutput("frame_done_once", 32'(frameDoneSeen), 1);
    checkOutput("frame1_rd_bank", 32'(rd_bank), 0);

    // Second frame goes to bank 1; scan-out chases only past the threshold.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1 checkOutput("frame2_first_addr", 32'(wr_addr), 'h8000);
    writePixels(AHEAD - 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("rd_at_9599", 32'(rd_bank), 0);
    writePixels(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("rd_at_9600", 32'(rd_bank), 1);

    // Early restart with a coincident pixel.
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1 checkOutput("restart_pix_wr_en", 32'(wr_en), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("restart_cnt_1", 32'(restart_cnt), 1);
    checkOutput("restart_addr", 32'(wr_addr), 'h8000);
    writePixels(5000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("restart_cnt_2", 32'(restart_cnt), 2);
    checkOutput("restart_addr_bank_kept", 32'(wr_addr), 'h8000);

    // Freeze mid-frame at pointer 100.
    writePixels(100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    freeze = 1'b1;
    #1 checkOutput("freeze_wr_en", 32'(wr_en), 0);
    writePixels(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    freeze = 1'b0;
    #1 checkOutput("frozen_addr_held", 32'(wr_addr), 'h8064);
    checkOutput("frozen_wr_en", 32'(wr_en), 0);
    writePixels(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1 checkOutput("resume_addr", 32'(wr_addr), 'h8000);
    checkOutput("resume_wr_en", 32'(wr_en), 1);

    // Complete this frame in bank 1, then scan-out picks it when idle.
    writePixels(FRAME - 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("frame_b1_done", 32'(frame_done), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("rd_last_bank_1", 32'(rd_bank), 1);

    // Single-buffer mode forces bank 0 for writer and scan-out.
    double_buffer = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1 checkOutput("single_buf_addr", 32'(wr_addr), 'h0000);
    writePixels(49);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("single_buf_rd", 32'(rd_bank), 0);

    // Back to double buffering: below threshold scan-out shows last bank.
    double_buffer = 1'b1;
    writePixels(4950);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkOutput("rd_last_bank_after_db", 32'(rd_bank), 1);

    // Asynchronous reset mid-frame at pointer 12000.
    writePixels(7000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1 checkOutput("pre_reset_addr", 32'(wr_addr), 12000);
    checkOutput("frame_done_total", 32'(frameDoneSeen), 2);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_wr_en", 32'(wr_en), 0);
    checkOutput("async_wr_addr", 32'(wr_addr), 0);
    checkOutput("async_rd_bank", 32'(rd_bank), 0);
    checkOutput("async_frame_done", 32'(frame_done), 0);
    checkOutput("async_overflow", 32'(overflow), 0);
    checkOutput("async_restart_cnt", 32'(restart_cnt), 0);
    wr_pix = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_fb_bank_ctrl.md
Name: lcd_fb_bank_ctrl

Overview:
Double-buffer bank scheduler for the LCD frame buffer (2 banks x 2^ADDR_W entries of 15-bit pixels). It sequences the write side: it qualifies pixel strobes, generates write address/enable, and tracks frame completion, freeze and restarts. It also picks the bank the scan-out side reads at each output frame start. It sits between the PPU/blank-fill pixel source and the frame buffer RAM in the clk_sys domain. Scan-out frame-start events arrive already synchronised into clk_sys.

Parameters:
ADDR_W, 15, pixel address width per bank
FRAME_PIX, 23040, pixels per complete frame (160x144)
AHEAD_THRESH, 9600, write-pointer lead (160x60) above which scan-out may read the bank being written

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_frame_start  in  1  1-cycle pulse: pixel source begins a new frame (LCD enable, VBlank exit or blank-fill wrap)
wr_pix  in  1  1-cycle pixel strobe (already ce-qualified)
freeze  in  1  level: LCD freeze or SGB freeze; suppresses writes
double_buffer  in  1  level: 1 = two banks, 0 = single bank 0
rd_frame_start  in  1  1-cycle pulse: scan-out is about to start a frame
wr_en  out  1  RAM write enable (combinational from registered state and wr_pix)
wr_addr  out  ADDR_W+1  {in_bank, wr_ptr}
rd_bank  out  1  bank selected for scan-out
frame_done  out  1  1-cycle pulse: the last pixel of a frame was accepted
overflow  out  1  sticky: a wr_pix arrived while in DONE
restart_cnt  out  8  saturating count of frames restarted before completion

Behaviour:
- Reset (async, reset_n=0): state=IDLE, in_bank=0, wr_ptr=0, rd_bank=0, last_bank=0, frame_done=0, overflow=0, restart_cnt=0.
- States: IDLE, WRITE, DONE, FROZEN. Transitions are taken on clk_sys edges, checked in priority order.
- Any state, freeze=1: go to FROZEN. wr_en=0. wr_ptr and in_bank hold.
- FROZEN, freeze=0: go to IDLE. The next frame always starts with wr_frame_start.
- IDLE, wr_frame_start: go to WRITE, wr_ptr=0, in_bank held. wr_pix in IDLE is ignored and does not set overflow.
- WRITE:
  - wr_en = wr_pix & ~wr_frame_start & ~freeze.
  - Each accepted pixel increments wr_ptr.
  - Pixel accepted at wr_ptr==FRAME_PIX-1: go to DONE, frame_done=1 next cycle, last_bank<=in_bank, wr_ptr holds FRAME_PIX-1.
  - wr_frame_start before completion: wr_ptr=0, stay in WRITE, no bank toggle, restart_cnt+1 (saturates at 255). The coincident wr_pix is dropped.
- DONE:
  - wr_frame_start: in_bank<=~in_bank if double_buffer=1, else in_bank<=0. wr_ptr=0, go to WRITE. The coincident wr_pix is dropped.
  - wr_pix in DONE: wr_en=0, overflow<=1.
- Scan-out, on rd_frame_start:
  - double_buffer=0: rd_bank<=0.
  - Else if state==WRITE and wr_ptr>=AHEAD_THRESH: rd_bank<=in_bank.
  - Else: rd_bank<=last_bank.
  - rd_bank changes only on rd_frame_start.
- Simultaneous events: the rd_frame_start decision uses pre-edge state, in_bank and wr_ptr, even when wr_frame_start or completion happens in the same cycle.
- A double_buffer change takes effect at the next bank toggle / rd_frame_start; there are no mid-frame bank changes.
- Width rules: wr_ptr is ADDR_W bits and never exceeds FRAME_PIX-1. A static check requires FRAME_PIX<=2^ADDR_W and AHEAD_THRESH<FRAME_PIX.

Decomposition:
- Package lcd_fb_pkg holds:
  - state enum fb_state_t {IDLE, WRITE, DONE, FROZEN};
  - localparams LCD_W=160, LCD_H=144, FRAME_PIX=LCD_W*LCD_H;
  - AHEAD_THRESH default LCD_W*60.
- Single module, no sub-module; the FSM, pointer and read selector share state too tightly to split.

Test Plan:
- Reset, wr_frame_start, 23040 wr_pix, wr_frame_start -> frame_done once after pixel 23040; wr_addr runs 0x0000..0x59FF, then 0x8000; rd_bank stays 0.
- Double-buffered, second frame at wr_ptr=9600 when rd_frame_start pulses -> rd_bank=1. Repeat at wr_ptr=9599 -> rd_bank=0 (last_bank).
- wr_frame_start at wr_ptr=5000 -> wr_ptr=0, in_bank unchanged, restart_cnt=1, coincident wr_pix has wr_en=0.
- freeze high mid-frame at wr_ptr=100 -> wr_en=0 for all strobes, state FROZEN. freeze low, then wr_pix -> ignored until wr_frame_start; writing resumes at addr {in_bank,0}.
- Complete frame, then 3 extra wr_pix -> overflow=1 (sticky), wr_en=0. double_buffer=0, next wr_frame_start -> in_bank=0, rd_frame_start -> rd_bank=0.
- reset_n pulled low mid-WRITE (wr_ptr=12000) -> all outputs reach reset values asynchronously, before the next clk_sys edge.
